// File: rtl/wave_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : wave_sequencer_if
//  Description : Host/config and generator-side signal bundle for the
//                wave_sequencer. The master modport is the host side
//                (table writes, playback control, generator feedback); the
//                slave modport is the sequencer itself.
//  Revision    : 1.0  initial release
// ============================================================================
interface wave_sequencer_if #(
    parameter int AW    = 3,
    parameter int RPT_W = 4
);
    // Table write port
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [3:0]       wr_on;
    logic [3:0]       wr_off;
    logic [RPT_W-1:0] wr_rpt;
    logic             wr_err;

    // Playback control
    logic [AW-1:0]    last_idx;
    logic             loop_mode;
    logic             start;
    logic             stop;

    // Generator feedback and configuration
    logic             wave_in;
    logic [3:0]       on_us;
    logic [3:0]       off_us;

    // Status
    logic [AW-1:0]    idx;
    logic             busy;
    logic             done;

    modport master (
        output wr_en, wr_addr, wr_on, wr_off, wr_rpt,
        output last_idx, loop_mode, start, stop, wave_in,
        input  wr_err, on_us, off_us, idx, busy, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_on, wr_off, wr_rpt,
        input  last_idx, loop_mode, start, stop, wave_in,
        output wr_err, on_us, off_us, idx, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/wave_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : wave_sequencer
//  Description : Programmable pattern controller for the on/off pulse
//                generator. Plays back a table of (on_us, off_us, repeat)
//                entries, switching entries only on rising edges of the
//                generator's wave output so no period is ever cut short.
//  Revision    : 1.0  initial release
// ============================================================================
module wave_sequencer #(
    parameter int         DEPTH    = 8,
    parameter int         AW       = 3,
    parameter int         RPT_W    = 4,
    parameter logic [3:0] IDLE_ON  = 4'd1,
    parameter logic [3:0] IDLE_OFF = 4'd1
) (
    input  wire logic       clk,
    input  wire logic       reset,
    wave_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_STOPPING = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Pattern table
    // ------------------------------------------------------------------
    logic [3:0]       r_tbl_on  [DEPTH];
    logic [3:0]       r_tbl_off [DEPTH];
    logic [RPT_W-1:0] r_tbl_rpt [DEPTH];
    logic             r_wr_err;

    logic             w_wr_bad;
    logic             w_wr_ok;

    // A zero on- or off-time would stall the generator, so such writes are
    // refused and flagged instead of stored.
    assign w_wr_bad = bus.wr_en & ((bus.wr_on == 4'd0) | (bus.wr_off == 4'd0));
    assign w_wr_ok  = bus.wr_en & ~w_wr_bad;

    // Table write port and rejection pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_tbl_on[i]  <= '0;
                r_tbl_off[i] <= '0;
                r_tbl_rpt[i] <= '0;
            end
            r_wr_err <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_tbl_on[bus.wr_addr]  <= bus.wr_on;
                r_tbl_off[bus.wr_addr] <= bus.wr_off;
                r_tbl_rpt[bus.wr_addr] <= bus.wr_rpt;
            end
            r_wr_err <= w_wr_bad;
        end
    end

    // ------------------------------------------------------------------
    // Period boundary detection
    // ------------------------------------------------------------------
    logic r_w1;
    logic r_w2;
    logic w_rise;

    // Two-stage capture of the generator output; a 0->1 step marks the
    // start of a new period.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_w1 <= 1'b0;
            r_w2 <= 1'b0;
        end else begin
            r_w1 <= bus.wave_in;
            r_w2 <= r_w1;
        end
    end

    assign w_rise = r_w1 & ~r_w2;

    // ------------------------------------------------------------------
    // Playback control
    // ------------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_nxt;

    logic [RPT_W-1:0] r_rpt_cnt;
    logic [RPT_W-1:0] w_rpt_cnt_nxt;
    logic [RPT_W-1:0] r_cur_rpt;
    logic [AW-1:0]    r_last_idx;
    logic             r_loop;

    logic             w_load;
    logic [AW-1:0]    w_load_addr;
    logic             w_done_nxt;
    logic             w_begin;

    logic [3:0]       r_on_us;
    logic [3:0]       r_off_us;
    logic [AW-1:0]    r_idx;
    logic             r_busy;
    logic             r_done;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, entry-load and repeat-count decisions
    always_comb begin
        w_state_nxt   = r_state;
        w_rpt_cnt_nxt = r_rpt_cnt;
        w_load        = 1'b0;
        w_load_addr   = '0;
        w_done_nxt    = 1'b0;
        w_begin       = 1'b0;

        case (r_state)
            S_IDLE: begin
                // A simultaneous stop cancels the start request.
                if (bus.start && !bus.stop) begin
                    w_state_nxt   = S_RUN;
                    w_begin       = 1'b1;
                    w_load        = 1'b1;
                    w_load_addr   = '0;
                    w_rpt_cnt_nxt = '0;
                end
            end

            S_RUN: begin
                if (w_rise) begin
                    if (r_rpt_cnt != r_cur_rpt) begin
                        w_rpt_cnt_nxt = r_rpt_cnt + 1'b1;
                    end else if (r_idx != r_last_idx) begin
                        w_load        = 1'b1;
                        w_load_addr   = r_idx + 1'b1;
                        w_rpt_cnt_nxt = '0;
                    end else if (r_loop) begin
                        w_load        = 1'b1;
                        w_load_addr   = '0;
                        w_rpt_cnt_nxt = '0;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
                // The boundary is handled first; stop only matters if
                // playback is still going afterwards.
                if (bus.stop && (w_state_nxt == S_RUN)) begin
                    w_state_nxt = S_STOPPING;
                end
            end

            S_STOPPING: begin
                if (w_rise) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Registered generator configuration, status and active-entry copy
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rpt_cnt  <= '0;
            r_cur_rpt  <= '0;
            r_last_idx <= '0;
            r_loop     <= 1'b0;
            r_on_us    <= IDLE_ON;
            r_off_us   <= IDLE_OFF;
            r_idx      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_rpt_cnt <= w_rpt_cnt_nxt;
            r_done    <= w_done_nxt;
            r_busy    <= (w_state_nxt != S_IDLE);

            if (w_begin) begin
                r_last_idx <= bus.last_idx;
                r_loop     <= bus.loop_mode;
            end

            // The entry is copied at load time so later table writes to the
            // same address cannot disturb a period in progress.
            if (w_load) begin
                r_on_us   <= r_tbl_on[w_load_addr];
                r_off_us  <= r_tbl_off[w_load_addr];
                r_cur_rpt <= r_tbl_rpt[w_load_addr];
                r_idx     <= w_load_addr;
            end else if (w_state_nxt == S_IDLE) begin
                r_on_us   <= IDLE_ON;
                r_off_us  <= IDLE_OFF;
                r_cur_rpt <= '0;
                r_idx     <= '0;
            end
        end
    end

    assign bus.on_us  = r_on_us;
    assign bus.off_us = r_off_us;
    assign bus.idx    = r_idx;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.wr_err = r_wr_err;

endmodule
`default_nettype wire
